multiplier_shift_add: RTL and testbench
=======================================

MULTIPLIER_SHIFT_ADD -- requirements
Module: multiplier_shift_add

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 CLOCK  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 START  input  1  level request; sampled only in IDLE and DONE.
REQ-005 A  input  32  signed Q16.16 multiplicand; sampled only in LOAD.
REQ-006 B  input  32  signed Q16.16 multiplier; sampled only in LOAD.
REQ-007 Product  output  32  registered signed Q16.16 result.
REQ-008 Finish  output  1  registered; high exactly while the FSM is in DONE.
REQ-009 Overflow  output  1  registered; set when Product was saturated; valid while Finish=1.

Function
REQ-010 FSM states: IDLE, LOAD, MUL, FIX, DONE; one transition per rising edge.
REQ-011 IDLE: START=1 -> LOAD; otherwise stay.
REQ-012 LOAD -> MUL, unconditional; START ignored.
REQ-013 LOAD: latch |A| and |B| as 32-bit unsigned (0x80000000 -> magnitude 2^31); sign = A[31]^B[31]; clear 64-bit accumulator; iteration counter = 0.
REQ-014 MUL iteration: if multiplier LSB=1, add multiplicand, shifted by the iteration index, into the accumulator; shift the multiplier right by 1; counter +1.
REQ-015 MUL SHALL last exactly 32 cycles, then -> FIX; START ignored.
REQ-016 FIX: m = accumulator>>16 (truncation of magnitude, i.e. toward zero); latch Product and Overflow; -> DONE.
REQ-017 sign=0: m > 0x7FFFFFFF -> Product=0x7FFFFFFF, Overflow=1; else Product=m, Overflow=0.
REQ-018 sign=1: m > 0x80000000 -> Product=0x80000000, Overflow=1; else Product = two's complement of m, Overflow=0.
REQ-019 m=0 SHALL give Product=0x00000000 regardless of sign.
REQ-020 DONE: Finish=1; Product and Overflow held stable; START=1 -> stay in DONE; START=0 -> IDLE, with Finish=0 from that edge.
REQ-021 Latency: counting the edge that samples START=1 in IDLE as edge 1, Finish and Product SHALL update at edge 35.
REQ-022 Product and Overflow SHALL change only in FIX or on reset; they hold their last value through IDLE, LOAD and MUL.
REQ-023 A and B changes outside LOAD SHALL NOT affect the result in progress.
REQ-024 Back-to-back requests: a new START is accepted only after at least one cycle in IDLE.

Reset
REQ-025 reset=1 at a rising edge SHALL force IDLE, Product=0, Finish=0, Overflow=0, accumulator=0, counter=0, from any state.
REQ-026 reset SHALL take priority over START and over any in-progress iteration.
REQ-027 After reset is released, the first START SHALL behave exactly as after power-up reset.

Verification
REQ-028 A=0x00020000, B=0x00030000, START pulse -> Finish at edge 35, Product=0x00060000, Overflow=0.
REQ-029 A=0xFFFF8000, B=0x00040000 -> Product=0xFFFE0000; A=0xFFFFFFFF, B=0x00008000 -> Product=0x00000000 (toward zero).
REQ-030 A=0x7FFFFFFF, B=0x7FFFFFFF -> Product=0x7FFFFFFF, Overflow=1; A=0x80000000, B=0x80000000 -> Product=0x7FFFFFFF, Overflow=1.
REQ-031 A=0x80000000, B=0x00010000 -> Product=0x80000000, Overflow=0.
REQ-032 reset asserted at MUL iteration 10 -> next edge: Finish=0, Product=0, state IDLE; a fresh START with 2.0*3.0 -> 0x00060000 at edge 35.
REQ-033 START held high through DONE -> Finish stays 1, Product stable; drop START -> IDLE next edge, Finish=0; A/B toggled during MUL -> result unchanged.

Source files
------------

// File: rtl/multiplier_shift_add.sv
// Signed Q16.16 sequential shift-and-add multiplier.
// Multiplies the magnitudes over 32 cycles, then rounds toward zero,
// saturates to the Q16.16 range and reapplies the sign.
module multiplier_shift_add (
   input  logic        CLOCK,
   input  logic        reset,
   input  logic        START,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] Product,
   output logic        Finish,
   output logic        Overflow
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_MUL  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic [31:0] r_mcand;
   logic [31:0] r_mplier;
   logic        r_sign;
   logic [63:0] r_acc;
   logic [4:0]  r_cnt;
   logic [31:0] r_product;
   logic        r_finish;
   logic        r_overflow;

   logic [63:0] w_addend;
   logic [47:0] w_m;
   logic [31:0] w_fix_product;
   logic        w_fix_overflow;

   // Unsigned magnitude of a two's complement word; 0x80000000 maps to 2^31.
   function automatic logic [31:0] f_magnitude(input logic [31:0] v);
      logic [31:0] mag;
      if (v[31]) begin
         mag = ~v + 32'd1;
      end else begin
         mag = v;
      end
      return mag;
   endfunction

   assign w_addend = {32'd0, r_mcand} << r_cnt;
   assign w_m      = r_acc[63:16];

   // State register; reset wins over every other condition.
   always_ff @(posedge CLOCK) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode; START only matters in IDLE and DONE.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (START) begin
               w_next_state = S_LOAD;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_LOAD: w_next_state = S_MUL;
         S_MUL: begin
            if (r_cnt == 5'd31) begin
               w_next_state = S_FIX;
            end else begin
               w_next_state = S_MUL;
            end
         end
         S_FIX: w_next_state = S_DONE;
         S_DONE: begin
            if (START) begin
               w_next_state = S_DONE;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Truncate the fractional bits, saturate to the signed range, apply the sign.
   always_comb begin
      w_fix_product  = 32'd0;
      w_fix_overflow = 1'b0;
      if (w_m == 48'd0) begin
         w_fix_product  = 32'd0;
         w_fix_overflow = 1'b0;
      end else if (!r_sign) begin
         if (w_m > 48'h0000_7FFF_FFFF) begin
            w_fix_product  = 32'h7FFF_FFFF;
            w_fix_overflow = 1'b1;
         end else begin
            w_fix_product  = w_m[31:0];
            w_fix_overflow = 1'b0;
         end
      end else begin
         if (w_m > 48'h0000_8000_0000) begin
            w_fix_product  = 32'h8000_0000;
            w_fix_overflow = 1'b1;
         end else begin
            w_fix_product  = ~w_m[31:0] + 32'd1;
            w_fix_overflow = 1'b0;
         end
      end
   end

   // Datapath: operand capture, one shift-add step per MUL cycle, result latch in FIX.
   always_ff @(posedge CLOCK) begin
      if (reset) begin
         r_mcand    <= 32'd0;
         r_mplier   <= 32'd0;
         r_sign     <= 1'b0;
         r_acc      <= 64'd0;
         r_cnt      <= 5'd0;
         r_product  <= 32'd0;
         r_overflow <= 1'b0;
         r_finish   <= 1'b0;
      end else begin
         r_finish <= (w_next_state == S_DONE);
         case (r_state)
            S_LOAD: begin
               r_mcand  <= f_magnitude(A);
               r_mplier <= f_magnitude(B);
               r_sign   <= A[31] ^ B[31];
               r_acc    <= 64'd0;
               r_cnt    <= 5'd0;
            end
            S_MUL: begin
               if (r_mplier[0]) begin
                  r_acc <= r_acc + w_addend;
               end else begin
                  r_acc <= r_acc;
               end
               r_mplier <= {1'b0, r_mplier[31:1]};
               r_cnt    <= r_cnt + 5'd1;
            end
            S_FIX: begin
               r_product  <= w_fix_product;
               r_overflow <= w_fix_overflow;
            end
            default: begin
               r_acc <= r_acc;
            end
         endcase
      end
   end

   assign Product  = r_product;
   assign Finish   = r_finish;
   assign Overflow = r_overflow;

endmodule

// File: tb/tb_multiplier_shift_add.sv
// Scoreboard bench for multiplier_shift_add: the stimulus pushes hand-computed
// results, a negedge monitor pops one entry on every rising Finish.
module tb_multiplier_shift_add;

   logic        CLOCK = 1'b0;
   logic        reset;
   logic        START;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] Product;
   logic        Finish;
   logic        Overflow;

   typedef struct {
      logic [31:0] p;
      logic        o;
      int          edge_n;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        prev_fin = 1'b0;
   logic [31:0] last_p = 32'd0;

   multiplier_shift_add dut (
      .CLOCK    (CLOCK),
      .reset    (reset),
      .START    (START),
      .A        (A),
      .B        (B),
      .Product  (Product),
      .Finish   (Finish),
      .Overflow (Overflow)
   );

   always #5 CLOCK = ~CLOCK;

   // Rising-edge counter used for latency checks.
   always @(posedge CLOCK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks = checks + 1;
      if (act !== req) begin
         errors = errors + 1;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: on each rising Finish compare against the oldest expected result.
   always @(negedge CLOCK) begin
      if (Finish && !prev_fin) begin
         if (sb_q.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL unexpected_finish actual=1 required=0 (cycle %0d)", cyc);
         end else begin
            mon_e = sb_q.pop_front();
            chk("product", {32'd0, Product}, {32'd0, mon_e.p});
            chk("overflow", {63'd0, Overflow}, {63'd0, mon_e.o});
            chk("latency_edge", 64'(cyc), 64'(mon_e.edge_n));
         end
      end
      prev_fin = Finish;
   end

   // One multiplication; hold keeps START high from request through DONE.
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] p, input logic o, input bit hold);
      exp_t e;
      @(negedge CLOCK);
      A = a;
      B = b;
      START = 1'b1;
      e.p = p;
      e.o = o;
      e.edge_n = cyc + 35;
      sb_q.push_back(e);
      @(negedge CLOCK);
      START = hold;
      @(negedge CLOCK);
      A = ~a ^ 32'h5A5A_5A5A;
      B = b + 32'h0001_2345;
      chk("hold_in_mul", {32'd0, Product}, {32'd0, last_p});
      for (int i = 0; i < 60; i++) begin
         if (Finish) break;
         @(negedge CLOCK);
      end
      chk("finish_seen", {63'd0, Finish}, 64'd1);
      if (hold) begin
         for (int k = 0; k < 3; k++) begin
            @(negedge CLOCK);
            chk("done_hold_finish", {63'd0, Finish}, 64'd1);
            chk("done_hold_product", {32'd0, Product}, {32'd0, p});
         end
         START = 1'b0;
      end
      @(negedge CLOCK);
      chk("finish_drop", {63'd0, Finish}, 64'd0);
      chk("product_after_done", {32'd0, Product}, {32'd0, p});
      @(negedge CLOCK);
      last_p = p;
   endtask

   initial begin
      reset = 1'b1;
      START = 1'b0;
      A = 32'd0;
      B = 32'd0;
      repeat (3) @(negedge CLOCK);
      chk("reset_product", {32'd0, Product}, 64'd0);
      chk("reset_finish", {63'd0, Finish}, 64'd0);
      chk("reset_overflow", {63'd0, Overflow}, 64'd0);
      reset = 1'b0;
      @(negedge CLOCK);

      run_mul(32'h0002_0000, 32'h0003_0000, 32'h0006_0000, 1'b0, 1'b0);
      run_mul(32'hFFFF_8000, 32'h0004_0000, 32'hFFFE_0000, 1'b0, 1'b0);
      run_mul(32'hFFFF_FFFF, 32'h0000_8000, 32'h0000_0000, 1'b0, 1'b0);
      run_mul(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0);
      run_mul(32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
      run_mul(32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0);
      run_mul(32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
      run_mul(32'h0001_8000, 32'hFFFE_0000, 32'hFFFD_0000, 1'b0, 1'b0);
      run_mul(32'h0000_0003, 32'h0000_8000, 32'h0000_0001, 1'b0, 1'b0);
      run_mul(32'hFFFF_FFFD, 32'h0000_8000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_mul(32'h0000_0000, 32'hFFFF_0000, 32'h0000_0000, 1'b0, 1'b0);
      run_mul(32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 1'b0, 1'b1);

      // Abort a multiplication at MUL iteration 10 with reset.
      @(negedge CLOCK);
      A = 32'h0002_0000;
      B = 32'h0003_0000;
      START = 1'b1;
      @(negedge CLOCK);
      START = 1'b0;
      repeat (11) @(negedge CLOCK);
      reset = 1'b1;
      @(negedge CLOCK);
      chk("abort_finish", {63'd0, Finish}, 64'd0);
      chk("abort_product", {32'd0, Product}, 64'd0);
      chk("abort_overflow", {63'd0, Overflow}, 64'd0);
      reset = 1'b0;
      last_p = 32'd0;
      repeat (40) @(negedge CLOCK);
      chk("no_finish_after_abort", {63'd0, Finish}, 64'd0);
      run_mul(32'h0002_0000, 32'h0003_0000, 32'h0006_0000, 1'b0, 1'b0);

      repeat (3) @(negedge CLOCK);
      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
